// File: rtl/mem_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter_if
//
// Purpose:
//   Bundles the requester handshakes and the memory macro bus that
//   mem_port_arbiter sits between. Signal prefixes are from the arbiter's
//   point of view (i_ = into the arbiter, o_ = out of the arbiter).
//
// Signal summary:
//   IF requester : i_if_req, i_if_addr, o_if_gnt, o_if_done
//   DM requester : i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata, o_dm_gnt, o_dm_done
//   Shared read  : o_rdata (registered read data for every requester)
//   Memory macro : o_mem_cs, o_mem_we, o_mem_addr, o_mem_wdata, i_mem_rdata
//   Status       : o_arb_busy
//   Debug port   : i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata, o_dbg_gnt,
//                  o_dbg_done (present only when MEM_ARB_DBG_PORT_EN is defined)
//
// Modports:
//   slave  - used by the arbiter itself
//   master - used by whatever drives the requesters and models the memory
// ----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int DATA_W = 19,
    parameter int ADDR_W = 19
);
    logic              i_if_req;
    logic [ADDR_W-1:0] i_if_addr;
    logic              o_if_gnt;
    logic              o_if_done;

    logic              i_dm_req;
    logic              i_dm_we;
    logic [ADDR_W-1:0] i_dm_addr;
    logic [DATA_W-1:0] i_dm_wdata;
    logic              o_dm_gnt;
    logic              o_dm_done;

    logic [DATA_W-1:0] o_rdata;

    logic              o_mem_cs;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic [DATA_W-1:0] i_mem_rdata;

    logic              o_arb_busy;

`ifdef MEM_ARB_DBG_PORT_EN
    logic              i_dbg_req;
    logic              i_dbg_we;
    logic [ADDR_W-1:0] i_dbg_addr;
    logic [DATA_W-1:0] i_dbg_wdata;
    logic              o_dbg_gnt;
    logic              o_dbg_done;
`endif

    modport slave (
        input  i_if_req, i_if_addr,
        output o_if_gnt, o_if_done,
        input  i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata,
        output o_dm_gnt, o_dm_done,
        output o_rdata,
        output o_mem_cs, o_mem_we, o_mem_addr, o_mem_wdata,
        input  i_mem_rdata,
        output o_arb_busy
`ifdef MEM_ARB_DBG_PORT_EN
        ,
        input  i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata,
        output o_dbg_gnt, o_dbg_done
`endif
    );

    modport master (
        output i_if_req, i_if_addr,
        input  o_if_gnt, o_if_done,
        output i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata,
        input  o_dm_gnt, o_dm_done,
        input  o_rdata,
        input  o_mem_cs, o_mem_we, o_mem_addr, o_mem_wdata,
        output i_mem_rdata,
        input  o_arb_busy
`ifdef MEM_ARB_DBG_PORT_EN
        ,
        output i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata,
        input  o_dbg_gnt, o_dbg_done
`endif
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Shares one single-port memory between instruction fetch (IF) and data
//   memory (DM) requesters. DM normally wins, but after STARVE_MAX
//   consecutive DM grants taken while IF was waiting, IF is forced through.
//   One access is in flight at a time: IDLE -> BUSY (MEM_LAT cycles) -> RESP,
//   and RESP arbitrates again so back-to-back accesses take MEM_LAT+1 cycles.
//
// Ports:
//   i_clk    - clock
//   i_rst_n  - asynchronous active-low reset
//   io_bus   - mem_port_arbiter_if.slave (requesters, shared RDATA, memory bus,
//              busy flag)
//
// Optional feature:
//   MEM_ARB_DBG_PORT_EN - adds a debug requester with top priority. Its grants
//   leave the IF starvation counter untouched. Undefined: two requesters only.
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int DATA_W     = 19,
    parameter int ADDR_W     = 19,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    mem_port_arbiter_if.slave     io_bus
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;
    typedef enum logic [1:0] {OWN_IF, OWN_DM, OWN_DBG} owner_t;

    state_t            r_state;
    state_t            w_state_nxt;
    owner_t            r_owner;
    owner_t            w_win;
    logic              w_grant;
    logic              w_win_we;
    logic [ADDR_W-1:0] w_win_addr;
    logic [DATA_W-1:0] w_win_wdata;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [CNT_W-1:0]  r_cnt;
    logic [STV_W-1:0]  r_starve;
    logic [STV_W-1:0]  w_starve_nxt;
    logic [DATA_W-1:0] r_rdata;
    logic              w_busy;
    logic              w_resp;
    logic              w_first;

    assign w_busy  = (r_state == ST_BUSY);
    assign w_resp  = (r_state == ST_RESP);
    // The cycle counter is loaded with MEM_LAT-1 at the grant, so the first
    // BUSY cycle is the only one where it still holds that value.
    assign w_first = w_busy && (r_cnt == CNT_LAST);

    // Arbitration and starvation bookkeeping. Requests are only looked at
    // outside BUSY; an arbitration with IF idle clears the counter, except
    // that a debug grant leaves it exactly as it was.
    always_comb begin
        w_grant      = 1'b0;
        w_win        = OWN_IF;
        w_win_we     = 1'b0;
        w_win_addr   = io_bus.i_if_addr;
        w_win_wdata  = '0;
        w_starve_nxt = r_starve;
        if (r_state != ST_BUSY) begin
`ifdef MEM_ARB_DBG_PORT_EN
            if (io_bus.i_dbg_req) begin
                w_grant     = 1'b1;
                w_win       = OWN_DBG;
                w_win_we    = io_bus.i_dbg_we;
                w_win_addr  = io_bus.i_dbg_addr;
                w_win_wdata = io_bus.i_dbg_wdata;
            end else
`endif
            if (io_bus.i_if_req && (r_starve == STV_MAX)) begin
                w_grant      = 1'b1;
                w_win        = OWN_IF;
                w_starve_nxt = '0;
            end else if (io_bus.i_dm_req) begin
                w_grant     = 1'b1;
                w_win       = OWN_DM;
                w_win_we    = io_bus.i_dm_we;
                w_win_addr  = io_bus.i_dm_addr;
                w_win_wdata = io_bus.i_dm_wdata;
                if (!io_bus.i_if_req) begin
                    w_starve_nxt = '0;
                end else if (r_starve != STV_MAX) begin
                    w_starve_nxt = r_starve + 1'b1;
                end
            end else if (io_bus.i_if_req) begin
                w_grant      = 1'b1;
                w_win        = OWN_IF;
                w_starve_nxt = '0;
            end else begin
                w_starve_nxt = '0;
            end
        end
    end

    // Next-state logic: RESP behaves like IDLE for arbitration purposes,
    // BUSY leaves only once the latency counter has run down to zero.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_RESP: w_state_nxt = w_grant ? ST_BUSY : ST_IDLE;
            ST_BUSY:          if (r_cnt == '0) w_state_nxt = ST_RESP;
            default:          w_state_nxt = ST_IDLE;
        endcase
    end

    // State, latched access and read-data capture. RDATA is only written on
    // the edge that ends the last BUSY cycle of a read.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_owner  <= OWN_IF;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_cnt    <= '0;
            r_starve <= '0;
            r_rdata  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_starve <= w_starve_nxt;
            if (w_grant) begin
                r_owner <= w_win;
                r_we    <= w_win_we;
                r_addr  <= w_win_addr;
                r_wdata <= w_win_wdata;
                r_cnt   <= CNT_LAST;
            end else if (w_busy && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_busy && (r_cnt == '0) && !r_we) begin
                r_rdata <= io_bus.i_mem_rdata;
            end
        end
    end

    // All outputs decode from registered state so reset clears them at once.
    assign io_bus.o_if_gnt    = w_first && (r_owner == OWN_IF);
    assign io_bus.o_dm_gnt    = w_first && (r_owner == OWN_DM);
    assign io_bus.o_if_done   = w_resp && (r_owner == OWN_IF);
    assign io_bus.o_dm_done   = w_resp && (r_owner == OWN_DM);
    assign io_bus.o_rdata     = r_rdata;
    assign io_bus.o_mem_cs    = w_busy;
    assign io_bus.o_mem_we    = w_busy && r_we;
    assign io_bus.o_mem_addr  = w_busy ? r_addr : '0;
    assign io_bus.o_mem_wdata = w_busy ? r_wdata : '0;
    assign io_bus.o_arb_busy  = w_busy || w_resp;
`ifdef MEM_ARB_DBG_PORT_EN
    assign io_bus.o_dbg_gnt   = w_first && (r_owner == OWN_DBG);
    assign io_bus.o_dbg_done  = w_resp && (r_owner == OWN_DBG);
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Two arbiters share one clock: u_dut1 with MEM_LAT=1 and u_dut3 with
// MEM_LAT=3, each with its own reset and interface instance. Inputs change
// 1 time unit after the rising edge and outputs are sampled at that point.
// Build with +define+MEM_ARB_DBG_PORT_EN to include the debug-port scenario.
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int DATA_W = 19;
    localparam int ADDR_W = 19;
    localparam int STARVE = 4;
    localparam int LAT1   = 1;

    logic clk = 1'b0;
    logic rst1_n;
    logic rst3_n;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus1 ();
    mem_port_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus3 ();

    mem_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_LAT(LAT1), .STARVE_MAX(STARVE))
        u_dut1 (.i_clk(clk), .i_rst_n(rst1_n), .io_bus(bus1));

    mem_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_LAT(3), .STARVE_MAX(STARVE))
        u_dut3 (.i_clk(clk), .i_rst_n(rst3_n), .io_bus(bus3));

    // Control outputs packed as {if_gnt, if_done, dm_gnt, dm_done, cs, we, busy}
    function automatic logic [6:0] ctrl1();
        return {bus1.o_if_gnt, bus1.o_if_done, bus1.o_dm_gnt, bus1.o_dm_done,
                bus1.o_mem_cs, bus1.o_mem_we, bus1.o_arb_busy};
    endfunction

    function automatic logic [6:0] ctrl3();
        return {bus3.o_if_gnt, bus3.o_if_done, bus3.o_dm_gnt, bus3.o_dm_done,
                bus3.o_mem_cs, bus3.o_mem_we, bus3.o_arb_busy};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic zero1();
        bus1.i_if_req    = 1'b0;
        bus1.i_if_addr   = '0;
        bus1.i_dm_req    = 1'b0;
        bus1.i_dm_we     = 1'b0;
        bus1.i_dm_addr   = '0;
        bus1.i_dm_wdata  = '0;
        bus1.i_mem_rdata = '0;
`ifdef MEM_ARB_DBG_PORT_EN
        bus1.i_dbg_req   = 1'b0;
        bus1.i_dbg_we    = 1'b0;
        bus1.i_dbg_addr  = '0;
        bus1.i_dbg_wdata = '0;
`endif
    endtask

    task automatic zero3();
        bus3.i_if_req    = 1'b0;
        bus3.i_if_addr   = '0;
        bus3.i_dm_req    = 1'b0;
        bus3.i_dm_we     = 1'b0;
        bus3.i_dm_addr   = '0;
        bus3.i_dm_wdata  = '0;
        bus3.i_mem_rdata = '0;
`ifdef MEM_ARB_DBG_PORT_EN
        bus3.i_dbg_req   = 1'b0;
        bus3.i_dbg_we    = 1'b0;
        bus3.i_dbg_addr  = '0;
        bus3.i_dbg_wdata = '0;
`endif
    endtask

    task automatic test_reset();
        zero1();
        zero3();
        rst1_n = 1'b0;
        rst3_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ctrl1() !== 7'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl1: got %b expected %b", ctrl1(), 7'b0);
        end
        checks++;
        if ({bus1.o_mem_addr, bus1.o_mem_wdata, bus1.o_rdata} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_bus1: addr %h wdata %h rdata %h expected all 0",
                     bus1.o_mem_addr, bus1.o_mem_wdata, bus1.o_rdata);
        end
        checks++;
        if (ctrl3() !== 7'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl3: got %b expected %b", ctrl3(), 7'b0);
        end
        @(negedge clk);
        rst1_n = 1'b1;
        rst3_n = 1'b1;
        tick();
        checks++;
        if (ctrl1() !== 7'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: got %b expected %b", ctrl1(), 7'b0);
        end
    endtask

    task automatic test_if_read();
        bus1.i_if_req  = 1'b1;
        bus1.i_if_addr = 19'h00010;
        tick();
        checks++;
        if (ctrl1() !== 7'b1000101) begin
            errors++;
            $display("[TB] FAIL if_read_c1_ctrl: got %b expected %b", ctrl1(), 7'b1000101);
        end
        checks++;
        if (bus1.o_mem_addr !== 19'h00010) begin
            errors++;
            $display("[TB] FAIL if_read_addr: got %h expected %h", bus1.o_mem_addr, 19'h00010);
        end
        bus1.i_if_req    = 1'b0;
        bus1.i_mem_rdata = 19'h7ABCD;
        tick();
        checks++;
        if (ctrl1() !== 7'b0100001) begin
            errors++;
            $display("[TB] FAIL if_read_c2_ctrl: got %b expected %b", ctrl1(), 7'b0100001);
        end
        checks++;
        if (bus1.o_rdata !== 19'h7ABCD) begin
            errors++;
            $display("[TB] FAIL if_read_rdata: got %h expected %h", bus1.o_rdata, 19'h7ABCD);
        end
        bus1.i_mem_rdata = '0;
        tick();
    endtask

    task automatic test_dm_write();
        bus1.i_dm_req   = 1'b1;
        bus1.i_dm_we    = 1'b1;
        bus1.i_dm_addr  = 19'h40000;
        bus1.i_dm_wdata = 19'h12345;
        tick();
        checks++;
        if (ctrl1() !== 7'b0010111) begin
            errors++;
            $display("[TB] FAIL dm_write_c1_ctrl: got %b expected %b", ctrl1(), 7'b0010111);
        end
        checks++;
        if ({bus1.o_mem_addr, bus1.o_mem_wdata} !== {19'h40000, 19'h12345}) begin
            errors++;
            $display("[TB] FAIL dm_write_bus: got %h/%h expected %h/%h",
                     bus1.o_mem_addr, bus1.o_mem_wdata, 19'h40000, 19'h12345);
        end
        bus1.i_dm_req    = 1'b0;
        bus1.i_dm_we     = 1'b0;
        bus1.i_mem_rdata = 19'h55555;
        tick();
        checks++;
        if (ctrl1() !== 7'b0001001) begin
            errors++;
            $display("[TB] FAIL dm_write_c2_ctrl: got %b expected %b", ctrl1(), 7'b0001001);
        end
        checks++;
        if (bus1.o_rdata !== 19'h7ABCD) begin
            errors++;
            $display("[TB] FAIL dm_write_rdata_kept: got %h expected %h", bus1.o_rdata, 19'h7ABCD);
        end
        bus1.i_mem_rdata = '0;
        tick();
    endtask

    task automatic test_starvation();
        int order [6];
        int expOrder [6];
        int n;
        expOrder = '{2, 2, 2, 2, 1, 2};
        n = 0;
        bus1.i_if_req   = 1'b1;
        bus1.i_if_addr  = 19'h00100;
        bus1.i_dm_req   = 1'b1;
        bus1.i_dm_we    = 1'b0;
        bus1.i_dm_addr  = 19'h20000;
        for (int cyc = 0; cyc < 40 && n < 6; cyc++) begin
            tick();
            if (bus1.o_if_gnt) begin
                order[n] = 1;
                n++;
            end else if (bus1.o_dm_gnt) begin
                order[n] = 2;
                n++;
            end
        end
        checks++;
        if (n != 6) begin
            errors++;
            $display("[TB] FAIL starve_grant_count: got %0d expected %0d", n, 6);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (order[i] != expOrder[i]) begin
                errors++;
                $display("[TB] FAIL starve_order[%0d]: got %0d expected %0d (1=IF 2=DM)",
                         i, order[i], expOrder[i]);
            end
        end
        zero1();
        repeat (3) tick();
    endtask

    task automatic test_lat3_read();
        int csCycles;
        bus3.i_if_req  = 1'b1;
        bus3.i_if_addr = 19'h2A5A5;
        tick();
        checks++;
        if (ctrl3() !== 7'b1000101) begin
            errors++;
            $display("[TB] FAIL lat3_c1_ctrl: got %b expected %b", ctrl3(), 7'b1000101);
        end
        checks++;
        if (bus3.o_mem_addr !== 19'h2A5A5) begin
            errors++;
            $display("[TB] FAIL lat3_addr: got %h expected %h", bus3.o_mem_addr, 19'h2A5A5);
        end
        csCycles = 1;
        bus3.i_if_req    = 1'b0;
        bus3.i_mem_rdata = 19'h11111;
        tick();
        if (bus3.o_mem_cs) csCycles++;
        checks++;
        if ({bus3.o_if_gnt, bus3.o_if_done} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL lat3_c2_gnt_done: got %b expected %b",
                     {bus3.o_if_gnt, bus3.o_if_done}, 2'b00);
        end
        bus3.i_mem_rdata = 19'h22222;
        tick();
        if (bus3.o_mem_cs) csCycles++;
        bus3.i_mem_rdata = 19'h33333;
        tick();
        if (bus3.o_mem_cs) csCycles++;
        checks++;
        if (ctrl3() !== 7'b0100001) begin
            errors++;
            $display("[TB] FAIL lat3_c4_ctrl: got %b expected %b", ctrl3(), 7'b0100001);
        end
        checks++;
        if (csCycles != 3) begin
            errors++;
            $display("[TB] FAIL lat3_cs_cycles: got %0d expected %0d", csCycles, 3);
        end
        checks++;
        if (bus3.o_rdata !== 19'h33333) begin
            errors++;
            $display("[TB] FAIL lat3_rdata: got %h expected %h", bus3.o_rdata, 19'h33333);
        end
        bus3.i_mem_rdata = '0;
        tick();
    endtask

    task automatic test_reset_mid_access();
        bus3.i_if_req  = 1'b1;
        bus3.i_if_addr = 19'h00777;
        tick();
        bus3.i_if_req    = 1'b0;
        bus3.i_mem_rdata = 19'h44444;
        tick();
        #2;
        rst3_n = 1'b0;
        #1;
        checks++;
        if (ctrl3() !== 7'b0) begin
            errors++;
            $display("[TB] FAIL midreset_ctrl: got %b expected %b", ctrl3(), 7'b0);
        end
        checks++;
        if ({bus3.o_mem_addr, bus3.o_rdata} !== '0) begin
            errors++;
            $display("[TB] FAIL midreset_bus: addr %h rdata %h expected 0",
                     bus3.o_mem_addr, bus3.o_rdata);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (ctrl3() !== 7'b0) begin
                errors++;
                $display("[TB] FAIL midreset_hold[%0d]: got %b expected %b", i, ctrl3(), 7'b0);
            end
        end
        bus3.i_mem_rdata = '0;
        @(negedge clk);
        rst3_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ctrl3() !== 7'b0) begin
                errors++;
                $display("[TB] FAIL midreset_after[%0d]: got %b expected %b", i, ctrl3(), 7'b0);
            end
        end
    endtask

    // Transaction-level model: one grant record, the next edge at which the
    // arbiter may decide, and the IF starvation count.
    task automatic test_random();
        int g;
        int win;
        int arbEdge;
        int starve;
        int w;
        logic ifReq, dmReq, dmWe, wWe;
        logic [ADDR_W-1:0] ifAddr, dmAddr, wAddr;
        logic [DATA_W-1:0] dmWdata, wWdata, expRdata, drivenRdata;
        logic eIfGnt, eIfDone, eDmGnt, eDmDone, eCs, eWe, eBusy;
        logic [6:0] expCtrl;

        zero1();
        @(negedge clk);
        rst1_n = 1'b0;
        @(negedge clk);
        rst1_n = 1'b1;
        tick();
        g = -1; win = 0; arbEdge = 1; starve = 0;
        ifReq = 1'b0; dmReq = 1'b0; dmWe = 1'b0; wWe = 1'b0;
        ifAddr = '0; dmAddr = '0; wAddr = '0; dmWdata = '0; wWdata = '0;
        expRdata = '0; drivenRdata = '0;

        for (int c = 0; c < 400; c++) begin
            eIfGnt  = (g >= 0) && (c == g) && (win == 1);
            eDmGnt  = (g >= 0) && (c == g) && (win == 2);
            eIfDone = (g >= 0) && (c == g + LAT1) && (win == 1);
            eDmDone = (g >= 0) && (c == g + LAT1) && (win == 2);
            eCs     = (g >= 0) && (c >= g) && (c < g + LAT1);
            eBusy   = (g >= 0) && (c >= g) && (c <= g + LAT1);
            eWe     = eCs && wWe;
            expCtrl = {eIfGnt, eIfDone, eDmGnt, eDmDone, eCs, eWe, eBusy};
            if ((g >= 0) && (c == g + LAT1) && !wWe) expRdata = drivenRdata;

            checks++;
            if (ctrl1() !== expCtrl) begin
                errors++;
                $display("[TB] FAIL rand_ctrl@%0d: got %b expected %b", c, ctrl1(), expCtrl);
            end
            if (eCs) begin
                checks++;
                if (bus1.o_mem_addr !== wAddr) begin
                    errors++;
                    $display("[TB] FAIL rand_addr@%0d: got %h expected %h", c, bus1.o_mem_addr, wAddr);
                end
            end
            if (eWe) begin
                checks++;
                if (bus1.o_mem_wdata !== wWdata) begin
                    errors++;
                    $display("[TB] FAIL rand_wdata@%0d: got %h expected %h", c, bus1.o_mem_wdata, wWdata);
                end
            end
            checks++;
            if (bus1.o_rdata !== expRdata) begin
                errors++;
                $display("[TB] FAIL rand_rdata@%0d: got %h expected %h", c, bus1.o_rdata, expRdata);
            end

            // Requesters drop their request once granted, then maybe start another.
            if (g == c && win == 1) ifReq = 1'b0;
            if (g == c && win == 2) dmReq = 1'b0;
            if (!ifReq && $urandom_range(0, 2) != 0) begin
                ifReq  = 1'b1;
                ifAddr = ADDR_W'($urandom);
            end
            if (!dmReq && $urandom_range(0, 2) != 0) begin
                dmReq   = 1'b1;
                dmWe    = 1'($urandom_range(0, 1));
                dmAddr  = ADDR_W'($urandom);
                dmWdata = DATA_W'($urandom);
            end
            bus1.i_if_req   = ifReq;
            bus1.i_if_addr  = ifAddr;
            bus1.i_dm_req   = dmReq;
            bus1.i_dm_we    = dmWe;
            bus1.i_dm_addr  = dmAddr;
            bus1.i_dm_wdata = dmWdata;
            drivenRdata      = DATA_W'($urandom);
            bus1.i_mem_rdata = drivenRdata;

            if (c + 1 == arbEdge) begin
                w = 0;
                if (ifReq && starve == STARVE) w = 1;
                else if (dmReq)                w = 2;
                else if (ifReq)                w = 1;
                if (w == 2 && ifReq) starve = (starve < STARVE) ? starve + 1 : starve;
                else                 starve = 0;
                if (w != 0) begin
                    g       = c + 1;
                    win     = w;
                    wWe     = (w == 2) ? dmWe : 1'b0;
                    wAddr   = (w == 2) ? dmAddr : ifAddr;
                    wWdata  = dmWdata;
                    arbEdge = c + 1 + LAT1 + 1;
                end else begin
                    arbEdge = c + 2;
                end
            end
            tick();
        end
        zero1();
        repeat (3) tick();
    endtask

`ifdef MEM_ARB_DBG_PORT_EN
    task automatic test_dbg_priority();
        int order [7];
        int expOrder [7];
        int n;
        int dmCount;
        expOrder = '{2, 2, 2, 2, 3, 1, 2};
        n = 0;
        dmCount = 0;
        zero1();
        repeat (3) tick();
        bus1.i_if_req    = 1'b1;
        bus1.i_if_addr   = 19'h00200;
        bus1.i_dm_req    = 1'b1;
        bus1.i_dm_addr   = 19'h30000;
        bus1.i_dbg_addr  = 19'h7FFFF;
        for (int cyc = 0; cyc < 60 && n < 7; cyc++) begin
            tick();
            if (bus1.o_dbg_gnt) begin
                order[n] = 3;
                n++;
                bus1.i_dbg_req = 1'b0;
            end else if (bus1.o_if_gnt) begin
                order[n] = 1;
                n++;
            end else if (bus1.o_dm_gnt) begin
                order[n] = 2;
                n++;
                dmCount++;
                if (dmCount == 4) bus1.i_dbg_req = 1'b1;
            end
        end
        checks++;
        if (n != 7) begin
            errors++;
            $display("[TB] FAIL dbg_grant_count: got %0d expected %0d", n, 7);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (order[i] != expOrder[i]) begin
                errors++;
                $display("[TB] FAIL dbg_order[%0d]: got %0d expected %0d (1=IF 2=DM 3=DBG)",
                         i, order[i], expOrder[i]);
            end
        end
        zero1();
        repeat (3) tick();
    endtask
`endif

    initial begin
        test_reset();
        test_if_read();
        test_dm_write();
        test_starvation();
        test_lat3_read();
        test_reset_mid_access();
        test_random();
`ifdef MEM_ARB_DBG_PORT_EN
        test_dbg_priority();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified 19-bit memory between instruction fetch (IF) and data memory (DM) requesters, plus an optional debug requester.
- Sits between the control unit's fetch/load-store sequencing and the memory macro.
- Fixed-priority arbitration with a starvation guard for IF; models a fixed memory latency.
- One access in flight at a time.

Parameters:
- DATA_W, 19, memory word width
- ADDR_W, 19, memory address width
- MEM_LAT, 1, memory access cycles (>=1); MEM_RDATA is valid in the last BUSY cycle
- STARVE_MAX, 4, consecutive DM grants allowed while IF_REQ is pending before IF is forced

Ports:
- CLK  in  1  clock
- RST_N  in  1  async active-low reset
- IF_REQ  in  1  fetch request (read only)
- IF_ADDR  in  ADDR_W  fetch address
- IF_GNT  out  1  fetch accepted pulse
- IF_DONE  out  1  fetch complete pulse; RDATA valid
- DM_REQ  in  1  data request
- DM_WE  in  1  1=write, 0=read
- DM_ADDR  in  ADDR_W  data address
- DM_WDATA  in  DATA_W  write data
- DM_GNT  out  1  data accepted pulse
- DM_DONE  out  1  data complete pulse
- RDATA  out  DATA_W  registered read data, shared by all requesters
- MEM_CS  out  1  memory select
- MEM_WE  out  1  memory write enable
- MEM_ADDR  out  ADDR_W  memory address
- MEM_WDATA  out  DATA_W  memory write data
- MEM_RDATA  in  DATA_W  memory read data
- ARB_BUSY  out  1  high in BUSY and RESP

Behaviour:
- Clocking and reset: single clock CLK; reset RST_N is asynchronous and active-low.
- Reset values: all outputs 0; state IDLE; starvation counter 0.
- States:
  - IDLE: arbitrate.
  - BUSY: memory access, MEM_LAT cycles.
  - RESP: DONE cycle; arbitrates again.
- Arbitration (IDLE and RESP only; REQs are ignored in BUSY):
  - DM beats IF, unless the starvation counter == STARVE_MAX and IF_REQ=1, in which case IF wins.
  - At the arbitration edge, latch the winner id, address, WE and WDATA (IF: WE=0); go to BUSY.
  - No request: IDLE stays IDLE; RESP goes to IDLE.
- Starvation counter:
  - DM granted while IF_REQ=1: counter increments, saturating at STARVE_MAX.
  - IF granted, or IF_REQ=0 at any arbitration: counter cleared.
- BUSY:
  - Winner's GNT is high for the first BUSY cycle only.
  - MEM_CS=1, MEM_WE=latched WE, MEM_ADDR/MEM_WDATA=latched values, held for all MEM_LAT cycles.
  - Internal cycle counter counts MEM_LAT-1 down to 0.
  - On the edge leaving the last BUSY cycle: capture MEM_RDATA into RDATA (reads only) and go to RESP.
- RESP:
  - Winner's DONE=1 for exactly one cycle; MEM_CS=0.
  - RDATA holds its value until the next read capture. Writes leave RDATA unchanged.
- Requester rule: hold REQ/ADDR/WDATA stable until GNT; drop REQ the cycle after GNT unless issuing a new access. REQ high in RESP is treated as a new request.
- Latency with MEM_LAT=1:
  - REQ sampled in IDLE at cycle 0; GNT and MEM_CS in cycle 1; DONE and RDATA in cycle 2.
  - Back-to-back throughput: one access per MEM_LAT+1 cycles.
- Simultaneous IF_REQ and DM_REQ: DM wins unless starvation is forced; the loser keeps REQ high and is served in the following RESP arbitration.
- Reset mid-access: the access is abandoned immediately. No GNT or DONE is issued. MEM_CS drops asynchronously.
- Address wrap: none; addresses are passed through unchanged.

Optional Feature:
- Macro: MEM_ARB_DBG_PORT_EN
- Defined:
  - Adds ports DBG_REQ in 1, DBG_WE in 1, DBG_ADDR in ADDR_W, DBG_WDATA in DATA_W, DBG_GNT out 1, DBG_DONE out 1.
  - DBG has top priority, over the starvation rule and over DM.
  - A DBG grant neither increments nor clears the starvation counter.
- Undefined: ports absent; behaviour is exactly two-requester.

Test Plan:
- IF_REQ=1, IF_ADDR=0x00010, MEM_LAT=1, memory returns 0x7ABCD -> IF_GNT in cycle 1, MEM_CS=1/MEM_ADDR=0x00010 in cycle 1, IF_DONE and RDATA=0x7ABCD in cycle 2.
- DM write with DM_ADDR=0x40000, DM_WDATA=0x12345 -> MEM_WE=1 with that address/data for 1 cycle, DM_DONE next cycle, RDATA unchanged.
- IF_REQ and DM_REQ both held continuously (DM re-requesting after each GNT), STARVE_MAX=4 -> grant order DM,DM,DM,DM,IF,DM...
- MEM_LAT=3 read -> MEM_CS high exactly 3 cycles, DONE in cycle 4, RDATA equals MEM_RDATA from the 3rd BUSY cycle.
- RST_N pulled low in the 2nd BUSY cycle of a MEM_LAT=3 read -> all outputs 0 immediately, no DONE, IDLE after release.
- With MEM_ARB_DBG_PORT_EN, DBG/DM/IF requesting at once, starvation counter at max -> DBG granted first, then IF, then DM.
